// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a registered, two-entry (output + skid) valid/ready stage.
// Decoding is combinational on the request; the result appears one cycle after acceptance.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      raw_src,
  input  logic [2:0]       imm_source,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immediate,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int ENT_W = XLEN + TAG_W + 1;

  // Returns {illegal, immediate}; r[k] corresponds to instruction bit k+7.
  function automatic logic [XLEN:0] decode_imm(input logic [24:0] r, input logic [2:0] sel);
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [31:0] u_imm;
    logic        [4:0]  z_imm;
    logic        [5:0]  sh_imm;
    logic [XLEN-1:0]    imm;
    logic               ill;
    i_imm  = r[24:13];
    s_imm  = {r[24:18], r[4:0]};
    b_imm  = {r[24], r[0], r[23:18], r[4:1], 1'b0};
    j_imm  = {r[24], r[12:5], r[13], r[23:14], 1'b0};
    u_imm  = {r[24:5], 12'h000};
    z_imm  = r[12:8];
    // RV64 shift amounts carry one extra bit.
    sh_imm = {(XLEN == 64) ? r[18] : 1'b0, r[17:13]};
    imm    = '0;
    ill    = 1'b0;
    case (sel)
      3'b000:  imm = XLEN'(i_imm);
      3'b001:  imm = XLEN'(s_imm);
      3'b010:  imm = XLEN'(b_imm);
      3'b011:  imm = XLEN'(j_imm);
      3'b100:  imm = XLEN'(u_imm);
      3'b101:  imm = XLEN'(z_imm);
      3'b110:  imm = XLEN'(sh_imm);
      default: ill = 1'b1;
    endcase
    return {ill, imm};
  endfunction

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [ENT_W-1:0] out_data_q, out_data_d;
  logic [ENT_W-1:0] skid_data_q, skid_data_d;
  logic [XLEN:0]    dec;
  logic [ENT_W-1:0] new_entry;
  logic             accept;
  logic             handoff;

  always_comb begin
    dec       = decode_imm(raw_src, imm_source);
    new_entry = {dec[XLEN], in_tag, dec[XLEN-1:0]};
    accept    = in_valid & in_ready_q & ~flush;
    handoff   = out_valid_q & out_ready;

    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || handoff) begin
      // Output slot frees up: refill from skid first to keep order.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = new_entry;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = new_entry;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_data_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign in_ready                           = in_ready_q;
  assign out_valid                          = out_valid_q;
  assign {out_illegal, out_tag, immediate}  = out_data_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64 instances,
// then backpressure, flush and reset scenarios with hand-computed results.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [24:0] raw_src;
  logic [2:0]  imm_source;
  logic [4:0]  in_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] imm32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] imm64;
  logic [4:0]  out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .raw_src(raw_src), .imm_source(imm_source), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .immediate(imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .raw_src(raw_src), .imm_source(imm_source), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .immediate(imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                       input logic [4:0] tag);
    in_valid   = v;
    raw_src    = instr[31:7];
    imm_source = sel;
    in_tag     = tag;
  endtask

  localparam int NV = 9;
  logic [31:0] v_instr [NV];
  logic [2:0]  v_sel   [NV];
  logic [31:0] v_e32   [NV];
  logic [63:0] v_e64   [NV];
  logic        v_ill   [NV];

  initial begin
    v_instr = '{32'hFFF00093, 32'h800000B7, 32'h7FFFF0B7, 32'hFFDFF06F, 32'hFFDFF06F,
                32'hFE112E23, 32'hFE000CE3, 32'h340FD073, 32'h03F09093};
    v_sel   = '{3'b000, 3'b100, 3'b100, 3'b011, 3'b111, 3'b001, 3'b010, 3'b101, 3'b110};
    v_e32   = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFF000, 32'hFFFFFFFC, 32'h0,
                32'hFFFFFFFC, 32'hFFFFFFF8, 32'h1F, 32'h1F};
    v_e64   = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h7FFFF000,
                64'hFFFFFFFFFFFFFFFC, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                64'h1F, 64'h3F};
    v_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    check("rst_in_ready",  {63'b0, in_ready32},  64'd1);
    check("rst_imm",       {32'b0, imm32},       64'd0);
    check("rst_tag",       {59'b0, out_tag32},   64'd0);
    check("rst_illegal",   {63'b0, out_illegal32}, 64'd0);
    check("rst_in_ready64", {63'b0, in_ready64}, 64'd1);

    // Streaming decode table, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, v_instr[i], v_sel[i], 5'(i + 1));
      tick();
      check($sformatf("vec%0d_valid", i), {63'b0, out_valid32}, 64'd1);
      check($sformatf("vec%0d_imm32", i), {32'b0, imm32}, {32'b0, v_e32[i]});
      check($sformatf("vec%0d_imm64", i), imm64, v_e64[i]);
      check($sformatf("vec%0d_tag", i), {59'b0, out_tag32}, 64'(i + 1));
      check($sformatf("vec%0d_ill", i), {63'b0, out_illegal64}, {63'b0, v_ill[i]});
    end
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    tick();
    check("drain_valid", {63'b0, out_valid32}, 64'd0);

    // Backpressure: tag 1 held, tag 2 in skid, tag 3 stalls.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd1);
    tick();
    check("bp1_valid", {63'b0, out_valid32}, 64'd1);
    check("bp1_ready", {63'b0, in_ready32}, 64'd1);
    drive(1'b1, 32'h800000B7, 3'b100, 5'd2);
    tick();
    check("bp2_tag",   {59'b0, out_tag32}, 64'd1);
    check("bp2_ready", {63'b0, in_ready32}, 64'd0);
    drive(1'b1, 32'h340FD073, 3'b101, 5'd3);
    tick();
    check("bp3_tag",   {59'b0, out_tag32}, 64'd1);
    check("bp3_imm",   {32'b0, imm32}, 64'hFFFFFFFF);
    check("bp3_ready", {63'b0, in_ready32}, 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp4_tag",   {59'b0, out_tag32}, 64'd2);
    check("bp4_imm",   {32'b0, imm32}, 64'h80000000);
    check("bp4_ready", {63'b0, in_ready32}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    check("bp5_valid", {63'b0, out_valid32}, 64'd1);
    check("bp5_tag",   {59'b0, out_tag32}, 64'd3);
    check("bp5_imm",   {32'b0, imm32}, 64'h1F);
    tick();
    check("bp6_valid", {63'b0, out_valid32}, 64'd0);

    // Flush with one entry held and a request that would otherwise be accepted.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd4);
    tick();
    check("fl1_valid", {63'b0, out_valid32}, 64'd1);
    drive(1'b1, 32'h800000B7, 3'b100, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    check("fl1_out_valid", {63'b0, out_valid32}, 64'd0);
    check("fl1_in_ready",  {63'b0, in_ready32}, 64'd1);
    tick();
    check("fl1_no_ghost", {63'b0, out_valid32}, 64'd0);

    // Flush with both entries full.
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd6);
    tick();
    drive(1'b1, 32'h800000B7, 3'b100, 5'd7);
    tick();
    check("fl2_full_ready", {63'b0, in_ready32}, 64'd0);
    check("fl2_full_tag",   {59'b0, out_tag32}, 64'd6);
    drive(1'b1, 32'h340FD073, 3'b101, 5'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    check("fl2_out_valid", {63'b0, out_valid32}, 64'd0);
    check("fl2_in_ready",  {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("fl2_no_ghost1", {63'b0, out_valid32}, 64'd0);
    tick();
    check("fl2_no_ghost2", {63'b0, out_valid64}, 64'd0);

    // Reset while a result is held.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFDFF06F, 3'b111, 5'd9);
    tick();
    check("rh_valid", {63'b0, out_valid32}, 64'd1);
    check("rh_ill",   {63'b0, out_illegal32}, 64'd1);
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    check("rh_out_valid", {63'b0, out_valid32}, 64'd0);
    check("rh_in_ready",  {63'b0, in_ready32}, 64'd1);
    check("rh_imm64",     imm64, 64'd0);
    check("rh_tag",       {59'b0, out_tag32}, 64'd0);
    check("rh_ill0",      {63'b0, out_illegal32}, 64'd0);
    tick();
    check("rh_after", {63'b0, out_valid32}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
